// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lock ownership, read-return tagging and stall counter.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution (default: port 0 wins).
module dmem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [15:0]   stall_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       pick1;
    logic       gnt0_c;
    logic       gnt1_c;
    logic       deny;

`ifdef DMEM_ARB_RR_EN
    // rr_ptr names the port that wins the next IDLE conflict
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end

    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1) begin
            pick1 = rr_ptr;
        end else begin
            pick1 = req1;
        end
    end
`else
    always_comb begin
        pick1 = req1 && !req0;
    end
`endif

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        case (state)
            S_LOCK0: gnt0_c = req0;
            S_LOCK1: gnt1_c = req1;
            default: begin
                gnt0_c = req0 && !pick1;
                gnt1_c = req1 && pick1;
            end
        endcase
    end

    // Grants are forced low while reset is held, since reset is synchronous
    assign gnt0 = gnt0_c && rst_n;
    assign gnt1 = gnt1_c && rst_n;

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_LOCK0: state_nxt = lock0 ? S_LOCK0 : S_IDLE;
            S_LOCK1: state_nxt = lock1 ? S_LOCK1 : S_IDLE;
            default: begin
                if (gnt0 && lock0) begin
                    state_nxt = S_LOCK0;
                end else if (gnt1 && lock1) begin
                    state_nxt = S_LOCK1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign mem_re   = gnt0 || gnt1;
    assign mem_we   = (gnt0 && we0) || (gnt1 && we1);
    assign mem_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
    assign mem_wd   = gnt0 ? wd0 : (gnt1 ? wd1 : '0);

    assign deny = (req0 && !gnt0) || (req1 && !gnt1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stall_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (deny && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    generate
        if (MEM_LATENCY == 0) begin : g_async
            assign rvalid0 = gnt0 && !we0;
            assign rvalid1 = gnt1 && !we1;
        end else begin : g_sync
            // Owner tag: which port's read is returning this cycle
            logic tag_v;
            logic tag_p;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tag_v <= 1'b0;
                    tag_p <= 1'b0;
                end else begin
                    tag_v <= (gnt0 && !we0) || (gnt1 && !we1);
                    tag_p <= gnt1;
                end
            end

            assign rvalid0 = rst_n && tag_v && !tag_p;
            assign rvalid1 = rst_n && tag_v && tag_p;
        end
    endgenerate

    assign rd0 = rvalid0 ? mem_rd : '0;
    assign rd1 = rvalid1 ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one async-memory and one BSRAM instance on shared stimulus.
// Expected values follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wd0, wd1, mem_rd;

    logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_re, a_we;
    logic [31:0] a_rd0, a_rd1, a_addr, a_wd;
    logic [15:0] a_stall;

    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_re, b_we;
    logic [31:0] b_rd0, b_rd1, b_addr, b_wd;
    logic [15:0] b_stall;

    int n_chk;
    int n_fail;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(a_gnt0), .gnt1(a_gnt1),
        .rvalid0(a_rv0), .rvalid1(a_rv1), .rd0(a_rd0), .rd1(a_rd1),
        .mem_re(a_re), .mem_we(a_we), .mem_addr(a_addr), .mem_wd(a_wd),
        .mem_rd(mem_rd), .stall_cnt(a_stall)
    );

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(b_gnt0), .gnt1(b_gnt1),
        .rvalid0(b_rv0), .rvalid1(b_rv1), .rd0(b_rd0), .rd1(b_rd1),
        .mem_re(b_re), .mem_we(b_we), .mem_addr(b_addr), .mem_wd(b_wd),
        .mem_rd(mem_rd), .stall_cnt(b_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; mem_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [2:0] exp_g1;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_in();
`ifdef DMEM_ARB_RR_EN
        exp_g1 = 3'b010;
`else
        exp_g1 = 3'b000;
`endif

        // Outputs held low during reset even with a live request
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rst_gnt0", a_gnt0, 0);
        check("rst_gnt1", b_gnt1, 0);
        check("rst_mem_re", a_re, 0);
        check("rst_mem_we", b_we, 0);
        @(negedge clk);
        idle_in();
        #1;
        check("rst_stall", b_stall, 0);
        rst_n = 1'b1;

        // Async read returns in the grant cycle
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h10; mem_rd = 32'hDEADBEEF;
        #1;
        check("l0_gnt0", a_gnt0, 1);
        check("l0_mem_re", a_re, 1);
        check("l0_mem_addr", a_addr, 32'h10);
        check("l0_rvalid0", a_rv0, 1);
        check("l0_rd0", a_rd0, 32'hDEADBEEF);
        check("l0_rvalid1", a_rv1, 0);
        check("l1_rv0_early", b_rv0, 0);
        @(negedge clk);
        idle_in(); mem_rd = 32'hCAFEF00D;
        #1;
        check("l1_rvalid0", b_rv0, 1);
        check("l1_rd0", b_rd0, 32'hCAFEF00D);
        check("idle_mem_re", b_re, 0);
        check("idle_mem_addr", b_addr, 0);
        check("l0_rd0_idle", a_rd0, 0);

        // Simultaneous reads for 3 cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0 = 1'b1; req1 = 1'b1;
            addr0 = 32'h100 + i; addr1 = 32'h200 + i;
            mem_rd = 32'hA0000000 + i;
            #1;
            check("conf_gnt0", b_gnt0, !exp_g1[i]);
            check("conf_gnt1", b_gnt1, exp_g1[i]);
            check("conf_addr", b_addr,
                  exp_g1[i] ? 32'h200 + i : 32'h100 + i);
            check("conf_l0_rv0", a_rv0, !exp_g1[i]);
            check("conf_l0_rv1", a_rv1, exp_g1[i]);
            if (i == 0) begin
                check("conf_rv_first", {b_rv0, b_rv1}, 0);
            end else begin
                check("conf_rv0", b_rv0, !exp_g1[i-1]);
                check("conf_rv1", b_rv1, exp_g1[i-1]);
                check("conf_rd", b_rd0 | b_rd1, 32'hA0000000 + i);
            end
        end
        @(negedge clk);
        idle_in(); mem_rd = 32'hA0000003;
        #1;
        check("conf_rv0_last", b_rv0, !exp_g1[2]);
        check("conf_rv1_last", b_rv1, exp_g1[2]);
        check("conf_rd_last", b_rd0 | b_rd1, 32'hA0000003);
        check("conf_stall_l1", b_stall, 3);
        check("conf_stall_l0", a_stall, 3);

        // Port 1 write with lock, port 0 waits for release
        do_reset();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1;
        addr1 = 32'h40; wd1 = 32'h5;
        #1;
        check("lk_gnt1", b_gnt1, 1);
        check("lk_mem_we", b_we, 1);
        check("lk_mem_wd", b_wd, 32'h5);
        check("lk_mem_addr", b_addr, 32'h40);
        check("lk_wr_rv1", a_rv1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req1 = 1'b0; we1 = 1'b0;
            lock1 = (i < 2);
            req0 = 1'b1; addr0 = 32'h80;
            #1;
            check("lk_gnt0_blocked", b_gnt0, 0);
            check("lk_mem_re_blk", b_re, 0);
        end
        @(negedge clk);
        lock1 = 1'b0;
        #1;
        check("lk_gnt0_free", b_gnt0, 1);
        check("lk_addr_free", b_addr, 32'h80);
        @(negedge clk);
        idle_in();
        #1;
        check("lk_wr_no_rv", b_rv1, 0);
        check("lk_stall", b_stall, 3);

        // Lock0 drop: port 0 still granted in the release cycle
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; wd0 = 32'h77;
        #1;
        check("l0lk_gnt0", b_gnt0, 1);
        @(negedge clk);
        lock0 = 1'b0; req1 = 1'b1; addr1 = 32'h44;
        #1;
        check("l0rel_gnt0", b_gnt0, 1);
        check("l0rel_gnt1", b_gnt1, 0);
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0;
        #1;
        check("l0rel_gnt1_next", b_gnt1, 1);
        check("l0rel_addr", b_addr, 32'h44);

        // Read accepted, then reset: no rvalid, FSM back to IDLE
        do_reset();
        @(negedge clk);
        req0 = 1'b1; lock0 = 1'b1; addr0 = 32'h10;
        #1;
        check("rr_gnt0", b_gnt0, 1);
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        check("rr_rv_inrst", b_rv0, 0);
        check("rr_gnt_inrst", b_gnt0 | b_gnt1, 0);
        @(negedge clk);
        rst_n = 1'b1; req1 = 1'b1; addr1 = 32'h20;
        #1;
        check("rr_rv_after", b_rv0, 0);
        check("rr_stall", b_stall, 0);
        check("rr_idle_gnt1", b_gnt1, 1);

        // Saturation of stall counter
        do_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        repeat (65534) @(negedge clk);
        #1;
        check("sat_fffe", b_stall, 16'hFFFE);
        repeat (6) @(negedge clk);
        #1;
        check("sat_ffff", b_stall, 16'hFFFF);
        check("sat_ffff_l0", a_stall, 16'hFFFF);
        idle_in();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
